rr_mux8_arbiter: RTL and testbench

RR_MUX8_ARBITER -- requirements
Module: rr_mux8_arbiter

---
 rtl/rr_mux8_arbiter.sv | 116 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for eight level requesters. It drives a registered one-hot
// grant and the select of an 8:1 mux, with an optional hold-time limit per grant.
module rr_mux8_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] select,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = (MAX_HOLD > 255) ? 8'd255 : 8'(MAX_HOLD);
    localparam bit         HOLD_EN  = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] select_q, select_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    // req_rot[k] is the request of the requester k+1 places after the last owner.
    logic [7:0] req_rot;
    logic [2:0] offset;
    logic [2:0] pick;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_q + 3'(gi + 1)];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = 3'(k);
            end
        end
        pick = ptr_q + offset + 3'd1;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        select_d   = select_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = 8'd1 << pick;
                    select_d   = pick;
                    ptr_d      = pick;
                    hold_cnt_d = 8'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                end
            end
            BUSY: begin
                // A release by the owner wins over both new requests and the hold limit.
                if (!req[ptr_q]) begin
                    state_d = TURN;
                    gnt_d   = 8'd0;
                end else if (HOLD_EN && (hold_cnt_q == HOLD_LIM)) begin
                    state_d   = TURN;
                    gnt_d     = 8'd0;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 8'd0;
            select_q   <= 3'd0;
            ptr_q      <= 3'd7;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            select_q   <= select_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign select  = select_q;
    assign valid   = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter: a vector table on a MAX_HOLD=4 instance
// plus rotation, self-regrant, hold-limit and saturation sequences.
module tb_rr_mux8_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] gnt4, gnt3, gnt0, gntb;
    logic [2:0] sel4, sel3, sel0, selb;
    logic       val4, val3, val0, valb;
    logic       tmo4, tmo3, tmo0, tmob;

    int checks = 0;
    int errors = 0;

    rr_mux8_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt4), .select(sel4), .valid(val4), .timeout(tmo4)
    );
    rr_mux8_arbiter #(.MAX_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt3), .select(sel3), .valid(val3), .timeout(tmo3)
    );
    rr_mux8_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt0), .select(sel0), .valid(val0), .timeout(tmo0)
    );
    rr_mux8_arbiter #(.MAX_HOLD(300)) dutb (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gntb), .select(selb), .valid(valb), .timeout(tmob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       tmo;
    } vec_t;

    vec_t vecs[21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag,
                             input logic [7:0] g, input logic [2:0] s,
                             input logic v, input logic t,
                             input logic [7:0] eg, input logic [2:0] es,
                             input logic et);
        checks++;
        if (g !== eg || s !== es || v !== (|eg) || t !== et) begin
            errors++;
            $display("FAIL %s: got gnt=%02h sel=%0d valid=%0b timeout=%0b, expected gnt=%02h sel=%0d valid=%0b timeout=%0b",
                     tag, g, s, v, t, eg, es, |eg, et);
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        vecs = '{
            '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0},
            '{1'b1, 8'h05, 8'h01, 3'd0, 1'b0},
            '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0},
            '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0},
            '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0},
            '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0},
            '{1'b1, 8'h00, 8'h00, 3'd2, 1'b0},
            '{1'b1, 8'h08, 8'h08, 3'd3, 1'b0},
            '{1'b1, 8'h48, 8'h08, 3'd3, 1'b0},
            '{1'b1, 8'h40, 8'h00, 3'd3, 1'b0},
            '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0},
            '{1'b1, 8'h40, 8'h40, 3'd6, 1'b0},
            '{1'b1, 8'h41, 8'h40, 3'd6, 1'b0},
            '{1'b1, 8'h41, 8'h40, 3'd6, 1'b0},
            '{1'b1, 8'h41, 8'h00, 3'd6, 1'b1},
            '{1'b1, 8'h41, 8'h01, 3'd0, 1'b0},
            '{1'b1, 8'h10, 8'h00, 3'd0, 1'b0},
            '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0},
            '{1'b0, 8'h10, 8'h00, 3'd0, 1'b0},
            '{1'b1, 8'h30, 8'h10, 3'd4, 1'b0},
            '{1'b1, 8'h00, 8'h00, 3'd4, 1'b0}
        };

        rst_n = 1'b0;
        req   = 8'h00;
        #2;

        // Table vectors on the MAX_HOLD=4 instance.
        for (int i = 0; i < 21; i++) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            step();
            $display("vec %0d: rst_n=%0b req=%02h -> gnt=%02h sel=%0d valid=%0b timeout=%0b",
                     i, rst_n, req, gnt4, sel4, val4, tmo4);
            check_out($sformatf("vec%0d", i), gnt4, sel4, val4, tmo4,
                      vecs[i].gnt, vecs[i].sel, vecs[i].tmo);
        end

        // All requesters held with MAX_HOLD=4: 4-cycle grants rotating 0..7,0.
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int r = 0; r < 9; r++) begin
            exp_g = 8'd1 << (r % 8);
            for (int c = 0; c < 4; c++) begin
                step();
                check_out($sformatf("rot_owner%0d_c%0d", r % 8, c), gnt4, sel4, val4, tmo4,
                          exp_g, 3'(r % 8), 1'b0);
            end
            if (r < 8) begin
                step();
                check_out($sformatf("rot_turn%0d", r), gnt4, sel4, val4, tmo4,
                          8'h00, 3'(r % 8), 1'b1);
            end
        end
        $display("rotation sequence done: gnt=%02h sel=%0d", gnt4, sel4);

        // Lone requester 5 with MAX_HOLD=3 gets regranted after each timeout slot.
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
        req   = 8'h20;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check_out($sformatf("solo5_r%0d_c%0d", r, c), gnt3, sel3, val3, tmo3,
                          8'h20, 3'd5, 1'b0);
            end
            step();
            check_out($sformatf("solo5_turn%0d", r), gnt3, sel3, val3, tmo3,
                      8'h00, 3'd5, 1'b1);
        end
        step();
        check_out("solo5_regrant", gnt3, sel3, val3, tmo3, 8'h20, 3'd5, 1'b0);
        $display("solo requester 5 sequence done: gnt=%02h sel=%0d", gnt3, sel3);

        // Long hold: no limit vs. a limit clamped to 255.
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
        req   = 8'h04;
        for (int i = 1; i <= 300; i++) begin
            step();
            check_out($sformatf("nolimit_c%0d", i), gnt0, sel0, val0, tmo0,
                      8'h04, 3'd2, 1'b0);
            if (i == 256) begin
                check_out($sformatf("clamp_c%0d", i), gntb, selb, valb, tmob,
                          8'h00, 3'd2, 1'b1);
            end else begin
                check_out($sformatf("clamp_c%0d", i), gntb, selb, valb, tmob,
                          8'h04, 3'd2, 1'b0);
            end
        end
        checks++;
        if (dut0.hold_cnt_q !== 8'd255) begin
            errors++;
            $display("FAIL hold_cnt_sat: got %0d expected 255", dut0.hold_cnt_q);
        end
        $display("long hold sequence done: hold_cnt=%0d", dut0.hold_cnt_q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
